// File: rtl/comp_mul_seq.sv
// comp_mul_seq: sequenced complex multiplier on one shared registered multiply slice
// with a post-adder; valid/ready on both sides, 1 result per 6 cycles.
module comp_mul_seq #(
  parameter int A_W = 16,
  parameter int B_W = 14,
  localparam int P_W = A_W + B_W + 1
) (
  input  logic           CLK_IN,
  input  logic           RST_IN,
  input  logic [A_W-1:0] A_RE_IN,
  input  logic [A_W-1:0] A_IM_IN,
  input  logic [B_W-1:0] B_RE_IN,
  input  logic [B_W-1:0] B_IM_IN,
  input  logic           CONJ_IN,
  input  logic           IN_VALID_IN,
  output logic           IN_READY_OUT,
  output logic [P_W-1:0] P_RE_OUT,
  output logic [P_W-1:0] P_IM_OUT,
  output logic           OUT_VALID_OUT,
  input  logic           OUT_READY_IN,
  output logic           BUSY_OUT
);
  localparam int M_W = A_W + B_W;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] ph_q, ph_d;
  logic signed [A_W-1:0] ar_q, ai_q, mx;
  logic signed [B_W-1:0] br_q, bi_q, my;
  logic conj_q, accept;
  logic signed [M_W-1:0] m_q, acc_q;
  logic signed [P_W-1:0] m_x, acc_x, re_sum, im_sum, re_q, pre_q, pim_q;
  assign IN_READY_OUT  = (state_q == S_IDLE) | ((state_q == S_DONE) & OUT_READY_IN);
  assign accept        = IN_VALID_IN & IN_READY_OUT;
  assign OUT_VALID_OUT = state_q == S_DONE;
  assign BUSY_OUT      = state_q == S_RUN;
  assign P_RE_OUT      = pre_q;
  assign P_IM_OUT      = pim_q;
  always_comb begin
    state_d = accept ? S_RUN
            : (state_q == S_RUN && ph_q == 3'd4) ? S_DONE
            : (state_q == S_DONE && OUT_READY_IN) ? S_IDLE : state_q;
    ph_d    = (state_q == S_RUN && ph_q != 3'd4) ? ph_q + 3'd1 : 3'd0;
    // issue order: ar*br, ai*bi, ar*bi, ai*br
    mx      = ph_q[0] ? ai_q : ar_q;
    my      = (ph_q == 3'd1 || ph_q == 3'd2) ? bi_q : br_q;
    m_x     = P_W'(m_q);
    acc_x   = P_W'(acc_q);
    re_sum  = conj_q ? acc_x + m_x : acc_x - m_x;
    im_sum  = conj_q ? m_x - acc_x : acc_x + m_x;
  end
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= S_IDLE;
      ph_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      conj_q <= 1'b0;
      m_q    <= '0;
      acc_q  <= '0;
      re_q   <= '0;
      pre_q  <= '0;
      pim_q  <= '0;
    end else begin
      if (accept) begin
        ar_q   <= A_RE_IN;
        ai_q   <= A_IM_IN;
        br_q   <= B_RE_IN;
        bi_q   <= B_IM_IN;
        conj_q <= CONJ_IN;
      end
      if (state_q == S_RUN) begin
        m_q <= M_W'(mx) * M_W'(my);
        if (ph_q == 3'd1 || ph_q == 3'd3) acc_q <= m_q;
        if (ph_q == 3'd2) re_q <= re_sum;
        if (ph_q == 3'd4) begin
          pre_q <= re_q;
          pim_q <= im_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_comp_mul_seq.sv
// tb_comp_mul_seq: scoreboard bench for comp_mul_seq; driver pushes expected results on
// accept, an independent monitor pops and compares on each output handshake.
module tb_comp_mul_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] a_re, a_im;
  logic [13:0] b_re, b_im;
  logic conj, in_valid, in_ready, out_valid, out_ready, busy;
  logic [30:0] p_re, p_im, hold_re, hold_im;
  int tests = 0, fails = 0;
  logic [61:0] sb[$];
  bit rnd_rdy = 1'b0;

  comp_mul_seq dut (
    .CLK_IN(clk), .RST_IN(rst), .A_RE_IN(a_re), .A_IM_IN(a_im), .B_RE_IN(b_re), .B_IM_IN(b_im),
    .CONJ_IN(conj), .IN_VALID_IN(in_valid), .IN_READY_OUT(in_ready), .P_RE_OUT(p_re),
    .P_IM_OUT(p_im), .OUT_VALID_OUT(out_valid), .OUT_READY_IN(out_ready), .BUSY_OUT(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // handshake completes at the coming edge, so sample just before it
  always @(negedge clk) begin : monitor
    logic [61:0] e;
    #4;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious result", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", {p_re, p_im}, e);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // called at a negedge; returns just after the accepting edge with valid dropped
  task automatic issue(input int ar, input int ai, input int br, input int bi, input bit cj,
                       input int ere, input int eim);
    a_re = ar[15:0]; a_im = ai[15:0]; b_re = br[13:0]; b_im = bi[13:0]; conj = cj;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #4;
      if (in_ready) begin
        sb.push_back({ere[30:0], eim[30:0]});
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      tick();
    end
    check("accept timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // cycles from the accept cycle to the first cycle with valid visible
  task automatic lat(input int exp, input bit poke);
    int n = 0;
    tick(); n++;
    check("busy in run", {busy, in_ready}, 2'b10);
    while (!out_valid && n < 20) begin
      if (poke && n == 2) begin
        a_re = 16'h1234; b_im = 14'h0abc; conj = ~conj; in_valid = 1'b1;
      end
      tick(); n++;
      in_valid = 1'b0;
    end
    check("latency", n, exp);
  endtask

  initial begin
    in_valid = 0; out_ready = 1; conj = 0;
    a_re = 0; a_im = 0; b_re = 0; b_im = 0;
    #2;
    check("reset state", {out_valid, busy, in_ready, p_re, p_im}, {3'b001, 62'd0});
    @(negedge clk); rst = 1'b0;
    tick();
    issue(3, 4, 5, 6, 0, -9, 38);          lat(6, 1'b0);
    tick(); issue(3, 4, 5, 6, 1, 39, 2);   lat(6, 1'b1);
    tick(); issue(-32768, -32768, -8192, -8192, 0, 0, 536870912); lat(6, 1'b0);
    tick(); issue(-32768, -32768, -8192, -8192, 1, 536870912, 0); lat(6, 1'b0);
    // stall with downstream not ready, then release with new operands waiting
    tick(); out_ready = 1'b0;
    issue(3, 4, 5, 6, 0, -9, 38); lat(6, 1'b0);
    hold_re = p_re; hold_im = p_im;
    a_re = 16'd7; a_im = 16'd2; b_re = 14'd3; b_im = 14'h3fff; conj = 0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold", {out_valid, in_ready, p_re, p_im}, {2'b10, hold_re, hold_im});
    end
    out_ready = 1'b1;
    issue(7, 2, 3, -1, 0, 23, -1); lat(6, 1'b0);
    tick(); issue(3, 4, 5, 6, 1, 39, 2); lat(6, 1'b0);
    // reset in the middle of an operation
    tick(); issue(7, 8, 9, 10, 0, -17, 142);
    tick(); tick(); tick();
    rst = 1'b1;
    #1 check("mid-run reset", {out_valid, busy, in_ready, p_re, p_im}, {3'b001, 62'd0});
    sb.delete();
    tick(); rst = 1'b0;
    repeat (8) tick();
    check("no result after reset", out_valid, 0);
    issue(1, 1, 1, -1, 0, 2, 0); lat(6, 1'b0);
    // random operands, gaps and backpressure against the arithmetic model
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic signed [15:0] ar, ai;
      logic signed [13:0] br, bi;
      bit cj;
      int re, im;
      ar = 16'($urandom); ai = 16'($urandom); br = 14'($urandom); bi = 14'($urandom);
      cj = 1'($urandom);
      if (i < 8) begin
        ar = (i & 1) ? -16'sd32768 : 16'sd32767;
        bi = (i & 2) ? -14'sd8192 : 14'sd8191;
      end
      re = cj ? int'(ar) * int'(br) + int'(ai) * int'(bi) : int'(ar) * int'(br) - int'(ai) * int'(bi);
      im = cj ? int'(ai) * int'(br) - int'(ar) * int'(bi) : int'(ar) * int'(bi) + int'(ai) * int'(br);
      tick();
      repeat ($urandom_range(0, 2)) tick();
      issue(int'(ar), int'(ai), int'(br), int'(bi), cj, re, im);
    end
    rnd_rdy = 1'b0;
    tick(); out_ready = 1'b1;
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) tick();
    check("drain", {31'd0, out_valid, sb.size()}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
